// File: rtl/aqp_sync_fifo.sv
// Parametrised single-clock FIFO with full-depth capacity, optional first-word-fall-through read,
// fill level, programmable almost flags, sticky overflow/underflow and synchronous flush.
module aqp_sync_fifo #(
  parameter int WIDTH        = 9,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_LEVEL  = 8,
  parameter int AEMPTY_LEVEL = 1,
  parameter bit FWFT         = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wrdata,
  input  logic                  wr_en,
  output logic [WIDTH-1:0]      rddata,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] AFULL_LV  = AFULL_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AEMPTY_LV = AEMPTY_LEVEL[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wrPtr;
  logic [DEPTH_LOG2:0]   r_rdPtr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [DEPTH_LOG2-1:0] w_wrIdx;
  logic [DEPTH_LOG2-1:0] w_rdIdx;
  logic [DEPTH_LOG2:0]   w_level;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wrAcc;
  logic                  w_rdAcc;
  logic [WIDTH-1:0]      w_rdData;

  // The extra pointer MSB is a wrap bit, so equal low bits mean empty or full depending on it.
  assign w_wrIdx = r_wrPtr[DEPTH_LOG2-1:0];
  assign w_rdIdx = r_rdPtr[DEPTH_LOG2-1:0];
  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (w_wrIdx == w_rdIdx) && (r_wrPtr[DEPTH_LOG2] != r_rdPtr[DEPTH_LOG2]);

  assign w_wrAcc = wr_en & ~w_full  & ~flush;
  assign w_rdAcc = rd_en & ~w_empty & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrAcc) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_rdAcc) r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)  r_overflow  <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wrAcc) r_mem[w_wrIdx] <= wrdata;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset reads back as zero.
      assign w_rdData = w_empty ? '0 : r_mem[w_rdIdx];
    end else begin : g_std
      logic [WIDTH-1:0] r_rdData;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rdData <= '0;
        end else if (w_rdAcc) begin
          r_rdData <= r_mem[w_rdIdx];
        end
      end

      assign w_rdData = r_rdData;
    end
  endgenerate

  assign rddata       = w_rdData;
  assign empty        = w_empty;
  assign full         = w_full;
  assign level        = w_level;
  assign almost_full  = (w_level >= AFULL_LV);
  assign almost_empty = (w_level <= AEMPTY_LV);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_aqp_sync_fifo.sv
// Scoreboard bench for aqp_sync_fifo: a default-parameter standard-read instance and a small
// 32-bit FWFT instance, checked against a level/flag model and a queue of expected words.
module tb_aqp_sync_fifo;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [8:0]  wrData;
  logic        wrEn;
  logic [8:0]  rdData;
  logic        rdEn;
  logic        empty;
  logic        full;
  logic        aFull;
  logic        aEmpty;
  logic [4:0]  level;
  logic        ovf;
  logic        udf;

  logic        fReset;
  logic        fFlush;
  logic [31:0] fWrData;
  logic        fWrEn;
  logic [31:0] fRdData;
  logic        fRdEn;
  logic        fEmpty;
  logic        fFull;
  logic        fAFull;
  logic        fAEmpty;
  logic [2:0]  fLevel;
  logic        fOvf;
  logic        fUdf;

  int          checkCount;
  int          passCount;
  int          mLevel;
  bit          mOvf;
  bit          mUdf;
  logic [31:0] expRd;
  logic [31:0] sbQ[$];

  aqp_sync_fifo dut (
    .clk(clk), .reset(reset), .flush(flush), .wrdata(wrData), .wr_en(wrEn),
    .rddata(rdData), .rd_en(rdEn), .empty(empty), .full(full),
    .almost_full(aFull), .almost_empty(aEmpty), .level(level),
    .overflow(ovf), .underflow(udf)
  );

  aqp_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1'b1)) dutF (
    .clk(clk), .reset(fReset), .flush(fFlush), .wrdata(fWrData), .wr_en(fWrEn),
    .rddata(fRdData), .rd_en(fRdEn), .empty(fEmpty), .full(fFull),
    .almost_full(fAFull), .almost_empty(fAEmpty), .level(fLevel),
    .overflow(fOvf), .underflow(fUdf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic checkFlags();
    checkOutput("level",        32'(level),  32'(mLevel));
    checkOutput("empty",        32'(empty),  32'(mLevel == 0));
    checkOutput("full",         32'(full),   32'(mLevel == 16));
    checkOutput("almost_full",  32'(aFull),  32'(mLevel >= 8));
    checkOutput("almost_empty", 32'(aEmpty), 32'(mLevel <= 1));
    checkOutput("overflow",     32'(ovf),    32'(mOvf));
    checkOutput("underflow",    32'(udf),    32'(mUdf));
    checkOutput("rddata",       32'(rdData), expRd);
  endtask

  // Model decides acceptance from its own level, then the DUT is clocked once and compared.
  task automatic applyStimulus(input bit wr, input logic [8:0] data, input bit rd);
    bit wrAcc;
    bit rdAcc;
    wrAcc = wr && (mLevel < 16);
    rdAcc = rd && (mLevel > 0);
    if (wr && mLevel == 16) mOvf = 1'b1;
    if (rd && mLevel == 0)  mUdf = 1'b1;
    if (rdAcc) expRd = sbQ.pop_front();
    if (wrAcc) sbQ.push_back(32'(data));
    mLevel += int'(wrAcc) - int'(rdAcc);
    wrData = data;
    wrEn   = wr;
    rdEn   = rd;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    checkFlags();
  endtask

  task automatic applyFlush(input bit wr, input bit rd);
    flush = 1'b1;
    wrEn  = wr;
    rdEn  = rd;
    wrData = 9'h0FF;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wrEn  = 1'b0;
    rdEn  = 1'b0;
    mLevel = 0;
    mOvf   = 1'b0;
    mUdf   = 1'b0;
    sbQ.delete();
    checkFlags();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    mLevel = 0;
    mOvf   = 1'b0;
    mUdf   = 1'b0;
    expRd  = '0;
    reset  = 1'b1;
    flush  = 1'b0;
    wrData = '0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    fReset = 1'b1;
    fFlush = 1'b0;
    fWrData = '0;
    fWrEn  = 1'b0;
    fRdEn  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkFlags();
    reset  = 1'b0;
    fReset = 1'b0;
    @(posedge clk);
    #1;

    // Fill with 0x000..0x00F, then drain in order.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 9'(i), 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 9'h000, 1'b1);

    // Refill, overflow write, full+read in one cycle, flush, then read from empty.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 9'(32 + i), 1'b0);
    applyStimulus(1'b1, 9'h1AA, 1'b0);
    applyStimulus(1'b1, 9'h1BB, 1'b1);
    applyFlush(1'b0, 1'b0);
    applyStimulus(1'b0, 9'h000, 1'b1);
    applyFlush(1'b0, 1'b0);

    // Level 5 steady state across many pointer wraps.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9'(256 + i), 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 9'(261 + i), 1'b1);

    // Asynchronous reset mid-cycle with data stored.
    #3;
    reset = 1'b1;
    #1;
    mLevel = 0;
    mOvf   = 1'b0;
    mUdf   = 1'b0;
    expRd  = '0;
    sbQ.delete();
    checkFlags();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Requests in a flush cycle are ignored and leave the sticky flags clear.
    applyFlush(1'b1, 1'b1);
    applyStimulus(1'b1, 9'h055, 1'b0);
    applyStimulus(1'b1, 9'h0AA, 1'b1);
    applyStimulus(1'b0, 9'h000, 1'b1);

    // FWFT instance.
    checkOutput("fwft reset empty",  32'(fEmpty), 32'd1);
    checkOutput("fwft reset rddata", fRdData, 32'h0);
    fWrData = 32'hDEADBEEF;
    fWrEn   = 1'b1;
    @(posedge clk);
    #1;
    fWrEn = 1'b0;
    checkOutput("fwft empty after write", 32'(fEmpty), 32'd0);
    checkOutput("fwft head",              fRdData,     32'hDEADBEEF);
    checkOutput("fwft level 1",           32'(fLevel), 32'd1);
    fRdEn = 1'b1;
    @(posedge clk);
    #1;
    fRdEn = 1'b0;
    checkOutput("fwft empty after pop", 32'(fEmpty), 32'd1);
    checkOutput("fwft underflow",       32'(fUdf),   32'd0);
    for (int i = 0; i < 4; i++) begin
      fWrData = 32'hC0DE_0000 + 32'(i);
      fWrEn   = 1'b1;
      @(posedge clk);
      #1;
      fWrEn = 1'b0;
    end
    checkOutput("fwft full",   32'(fFull),  32'd1);
    checkOutput("fwft afull",  32'(fAFull), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fwft order", fRdData, 32'hC0DE_0000 + 32'(i));
      fRdEn = 1'b1;
      @(posedge clk);
      #1;
      fRdEn = 1'b0;
    end
    checkOutput("fwft drained", 32'(fEmpty), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
